operand_entry: RTL

- Input-side writer for the calculator datapath. Turns the board's operator controls into a complete 16-bit operand: a 4-bit nibble switch bus, an active-low `next` push-button and a `level` target-select switch.
- Debounces `next` and collects four nibbles MSB-first.
- Presents the finished word to the ALU/control path through a valid/ready handshake.
- Drives one-hot digit-progress LEDs.

---
 rtl/operand_entry.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/operand_entry.sv
// operand_entry: turns the nibble switches, the active-low `next` button and
// the `level` switch into a 16-bit operand offered on a valid/ready port.
// Optional 7-seg echo of the last nibble: define OPERAND_ENTRY_ECHO_EN.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NIBBLES         = 4
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   next,
    input  logic [3:0]             Din,
    input  logic                   level,
    output logic [4*NIBBLES-1:0]   op_word,
    output logic                   op_sel,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic                   done,
    output logic [NIBBLES-1:0]     EDL,
    output logic                   busy,
    output logic [7:0]             seg_echo
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    logic [1:0]    r_sync;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_db_cnt;
    logic          r_press;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [NW-1:0] r_cnt;
    logic [W-1:0]  r_word;
    logic          r_sel;
    logic          r_done;
    logic          w_hs;

    // Synchronize the raw button, debounce it, and emit a one-cycle press on
    // each debounced falling edge (r_deb_d delays the edge by one register).
    always_ff @(posedge clk) begin
        if (clear) begin
            r_sync   <= 2'b11;
            r_deb    <= 1'b1;
            r_deb_d  <= 1'b1;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], next};
            r_deb_d <= r_deb;
            r_press <= r_deb_d & ~r_deb;
            if (r_sync[1] == r_deb) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_deb    <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_hs = op_valid & op_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (clear) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; presses in HOLD are ignored, not queued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (r_press) w_state_nxt = (NIBBLES == 1) ? S_HOLD : S_COLLECT;
            S_COLLECT: if (r_press && r_cnt == NW'(NIBBLES - 1)) w_state_nxt = S_HOLD;
            S_HOLD:    if (w_hs) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Operand assembly: shift nibbles in MSB-first; word survives the handshake.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_word <= '0;
            r_sel  <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_hs;
            case (r_state)
                S_IDLE: if (r_press) begin
                    r_word <= W'(Din);
                    r_sel  <= level;
                    r_cnt  <= NW'(1);
                end
                S_COLLECT: if (r_press) begin
                    r_word <= (r_word << 4) | W'(Din);
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_HOLD: if (w_hs) r_cnt <= '0;
                default: r_cnt <= '0;
            endcase
        end
    end

    // Outputs decoded from state and nibble count.
    always_comb begin
        op_valid = (r_state == S_HOLD);
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    EDL = NIBBLES'(1);
            S_COLLECT: EDL = NIBBLES'(1) << r_cnt;
            default:   EDL = '0;
        endcase
    end

    assign op_word = r_word;
    assign op_sel  = r_sel;
    assign done    = r_done;

`ifdef OPERAND_ENTRY_ECHO_EN
    logic       r_echo_vld;
    logic [3:0] r_echo_nib;
    logic [6:0] w_seg7;

    // Remember the last nibble actually accepted (not those dropped in HOLD).
    always_ff @(posedge clk) begin
        if (clear) begin
            r_echo_vld <= 1'b0;
            r_echo_nib <= 4'h0;
        end else if (r_press && r_state != S_HOLD) begin
            r_echo_vld <= 1'b1;
            r_echo_nib <= Din;
        end
    end

    // Hex to active-low {g,f,e,d,c,b,a}.
    always_comb begin
        case (r_echo_nib)
            4'h0: w_seg7 = 7'h40;  4'h1: w_seg7 = 7'h79;
            4'h2: w_seg7 = 7'h24;  4'h3: w_seg7 = 7'h30;
            4'h4: w_seg7 = 7'h19;  4'h5: w_seg7 = 7'h12;
            4'h6: w_seg7 = 7'h02;  4'h7: w_seg7 = 7'h78;
            4'h8: w_seg7 = 7'h00;  4'h9: w_seg7 = 7'h10;
            4'hA: w_seg7 = 7'h08;  4'hB: w_seg7 = 7'h03;
            4'hC: w_seg7 = 7'h46;  4'hD: w_seg7 = 7'h21;
            4'hE: w_seg7 = 7'h06;  default: w_seg7 = 7'h0E;
        endcase
    end

    // dp lights while the operand is on offer.
    assign seg_echo = r_echo_vld ? {~op_valid, w_seg7} : 8'hFF;
`else
    assign seg_echo = 8'hFF;
`endif

endmodule
